// File: rtl/regfile_arbiter.sv
// Two-requester round-robin arbiter in front of a small register file.
// Each granted access runs IDLE -> ACCESS -> DONE and ends with a one-cycle ack.
module regfile_arbiter #(
  parameter int DATA_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_a,
  input  logic              req_b,
  input  logic              we_a,
  input  logic              we_b,
  input  logic [1:0]        addr_a,
  input  logic [1:0]        addr_b,
  input  logic [DATA_W-1:0] wdata_a,
  input  logic [DATA_W-1:0] wdata_b,
  output logic              ack_a,
  output logic              ack_b,
  output logic [DATA_W-1:0] rdata,
  output logic              busy,
  output logic [1:0]        rf_read_addr1,
  input  logic [7:0]        rf_read_data1,
  output logic [1:0]        rf_write_addr,
  output logic [DATA_W-1:0] rf_write_data,
  output logic              rf_write_enable,
  output logic [7:0]        xfer_count
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t              state;
  state_t              state_nxt;

  logic                rr_b;       // 1: B wins a tie
  logic                own_b;
  logic                lat_we;
  logic [1:0]          lat_addr;
  logic [DATA_W-1:0]   lat_wdata;
  logic                grant_b;
  logic                any_req;

  generate
    if (DATA_W < 8) begin : g_unused_hi
      logic unused_rd_hi;
      assign unused_rd_hi = ^rf_read_data1[7:DATA_W];
    end
  endgenerate

  assign any_req = req_a | req_b;
  assign grant_b = req_b & (~req_a | rr_b);

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Write strobe is also gated by reset so an abort in ACCESS never reaches the file.
  always_comb begin
    state_nxt       = state;
    busy            = 1'b0;
    ack_a           = 1'b0;
    ack_b           = 1'b0;
    rf_write_enable = 1'b0;
    case (state)
      IDLE: begin
        if (any_req) state_nxt = ACCESS;
      end
      ACCESS: begin
        busy            = 1'b1;
        rf_write_enable = lat_we & ~reset;
        state_nxt       = DONE;
      end
      DONE: begin
        busy      = 1'b1;
        ack_a     = ~own_b;
        ack_b     = own_b;
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  assign rf_read_addr1 = lat_addr;
  assign rf_write_addr = lat_addr;
  assign rf_write_data = lat_wdata;

  always_ff @(posedge clk) begin
    if (reset) begin
      rr_b       <= 1'b0;
      own_b      <= 1'b0;
      lat_we     <= 1'b0;
      lat_addr   <= '0;
      lat_wdata  <= '0;
      rdata      <= '0;
      xfer_count <= '0;
    end else begin
      if (state == IDLE && any_req) begin
        own_b     <= grant_b;
        rr_b      <= ~grant_b;
        lat_we    <= grant_b ? we_b    : we_a;
        lat_addr  <= grant_b ? addr_b  : addr_a;
        lat_wdata <= grant_b ? wdata_b : wdata_a;
      end
      if (state == ACCESS && !lat_we) begin
        rdata <= rf_read_data1[DATA_W-1:0];
      end
      if (state == DONE) begin
        xfer_count <= xfer_count + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_regfile_arbiter.sv
// Randomized bench for regfile_arbiter with a transaction-level reference model
// and a simple 4-entry register file attached to the rf_* ports.
module tb_regfile_arbiter;

  localparam int DATA_W = 4;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              req_a = 1'b0, req_b = 1'b0;
  logic              we_a = 1'b0, we_b = 1'b0;
  logic [1:0]        addr_a = '0, addr_b = '0;
  logic [DATA_W-1:0] wdata_a = '0, wdata_b = '0;
  logic              ack_a, ack_b, busy, rf_write_enable;
  logic [DATA_W-1:0] rdata, rf_write_data;
  logic [1:0]        rf_read_addr1, rf_write_addr;
  logic [7:0]        rf_read_data1, xfer_count;

  regfile_arbiter #(.DATA_W(DATA_W)) dut (
    .clk(clk), .reset(reset),
    .req_a(req_a), .req_b(req_b), .we_a(we_a), .we_b(we_b),
    .addr_a(addr_a), .addr_b(addr_b), .wdata_a(wdata_a), .wdata_b(wdata_b),
    .ack_a(ack_a), .ack_b(ack_b), .rdata(rdata), .busy(busy),
    .rf_read_addr1(rf_read_addr1), .rf_read_data1(rf_read_data1),
    .rf_write_addr(rf_write_addr), .rf_write_data(rf_write_data),
    .rf_write_enable(rf_write_enable), .xfer_count(xfer_count)
  );

  always #5 clk = ~clk;

  // Register file: upper nibble is junk the arbiter must ignore.
  logic [7:0] rf_mem [4];
  assign rf_read_data1 = rf_mem[rf_read_addr1];
  always @(posedge clk) begin
    if (rf_write_enable) rf_mem[rf_write_addr] <= {rf_mem[rf_write_addr][7:4], rf_write_data};
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference model state
  bit         m_rr_b;
  logic [3:0] m_rf [4];
  logic [3:0] m_rdata;
  int         m_count;
  int         base;
  int         ack_exp_cyc = 0;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    req_a = 1'b0;
    req_b = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_ack", {ack_a, ack_b}, 0);
    check_eq("rst_we", rf_write_enable, 0);
    check_eq("rst_rdata", rdata, 0);
    check_eq("rst_count", xfer_count, 0);
    m_rr_b  = 1'b0;
    m_rdata = '0;
    m_count = 0;
    reset   = 1'b0;
    base    = cyc;
  endtask

  // Called at a negedge inside an IDLE cycle; returns at the next IDLE negedge.
  task automatic do_txn(input bit ra, input bit rb, input bit wa, input bit wb,
                        input logic [1:0] aa, input logic [1:0] ab,
                        input logic [3:0] da, input logic [3:0] db, input bit mutate);
    bit         w_b;
    bit         w_we;
    logic [1:0] w_addr;
    logic [3:0] w_data;
    req_a = ra; req_b = rb; we_a = wa; we_b = wb;
    addr_a = aa; addr_b = ab; wdata_a = da; wdata_b = db;
    check_eq("idle_busy", busy, 0);
    check_eq("idle_ack", {ack_a, ack_b}, 0);
    check_eq("idle_we", rf_write_enable, 0);
    check_eq("xfer_count", xfer_count, m_count % 256);
    check_eq("rdata_hold", rdata, m_rdata);
    if (!ra && !rb) begin
      @(negedge clk);
      check_eq("stay_idle", busy, 0);
      return;
    end
    w_b    = rb && (!ra || m_rr_b);
    m_rr_b = !w_b;
    w_we   = w_b ? wb : wa;
    w_addr = w_b ? ab : aa;
    w_data = w_b ? db : da;

    @(negedge clk);
    check_eq("acc_busy", busy, 1);
    check_eq("acc_ack", {ack_a, ack_b}, 0);
    check_eq("acc_we", rf_write_enable, w_we);
    check_eq("acc_waddr", rf_write_addr, w_addr);
    check_eq("acc_raddr", rf_read_addr1, w_addr);
    if (w_we) check_eq("acc_wdata", rf_write_data, w_data);
    if (mutate) begin
      req_a = 1'($urandom); req_b = 1'($urandom);
      we_a = 1'($urandom); we_b = 1'($urandom);
      addr_a = 2'($urandom); addr_b = 2'($urandom);
      wdata_a = 4'($urandom); wdata_b = 4'($urandom);
    end

    @(negedge clk);
    if (w_we) m_rf[w_addr] = w_data;
    else      m_rdata = m_rf[w_addr];
    check_eq("done_busy", busy, 1);
    check_eq("done_ack_a", ack_a, !w_b);
    check_eq("done_ack_b", ack_b, w_b);
    check_eq("done_we", rf_write_enable, 0);
    check_eq("done_rdata", rdata, m_rdata);
    check_eq("rf_content", rf_mem[w_addr][3:0], m_rf[w_addr]);
    if (ack_exp_cyc > 0) check_eq("ack_cycle", cyc - base + 1, ack_exp_cyc);
    m_count++;
    @(negedge clk);
  endtask

  task automatic abort_txn(input logic [1:0] x);
    logic [3:0] d;
    d = m_rf[x] ^ 4'hF;
    req_a = 1'b1; req_b = 1'b0; we_a = 1'b1; addr_a = x; wdata_a = d;
    @(negedge clk);
    check_eq("abort_in_access", busy, 1);
    reset = 1'b1;
    req_a = 1'b0;
    #1;
    check_eq("abort_we", rf_write_enable, 0);
    @(negedge clk);
    check_eq("abort_busy", busy, 0);
    check_eq("abort_ack", {ack_a, ack_b}, 0);
    check_eq("abort_rf", rf_mem[x][3:0], m_rf[x]);
    apply_reset();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int i = 0; i < 4; i++) begin
      rf_mem[i] = 8'($urandom);
      m_rf[i]   = rf_mem[i][3:0];
    end
    apply_reset();

    do_txn(1, 0, 1, 0, 2'd2, 2'd0, 4'h9, 4'h0, 0);   // A writes 9 to r2
    do_txn(0, 1, 0, 0, 2'd0, 2'd2, 4'h0, 4'h0, 0);   // B reads r2
    check_eq("read_back_9", rdata, 4'h9);
    do_txn(1, 0, 1, 0, 2'd1, 2'd3, 4'h5, 4'hC, 1);   // inputs scrambled in ACCESS
    do_txn(0, 0, 0, 0, 2'd0, 2'd0, 4'h0, 4'h0, 0);
    abort_txn(2'd3);

    for (int i = 0; i < 4; i++) begin
      ack_exp_cyc = 3 * (i + 1);
      do_txn(1, 1, 1'($urandom), 1'($urandom), 2'($urandom), 2'($urandom),
             4'($urandom), 4'($urandom), 0);
    end
    ack_exp_cyc = 0;

    for (int i = 0; i < 340; i++) begin
      do_txn(($urandom % 4) != 0, ($urandom % 4) != 0, 1'($urandom), 1'($urandom),
             2'($urandom), 2'($urandom), 4'($urandom), 4'($urandom), 1'($urandom));
    end
    req_a = 1'b0;
    req_b = 1'b0;
    do_txn(0, 0, 0, 0, 2'd0, 2'd0, 4'h0, 4'h0, 0);
    if (m_count >= 256) check_eq("wrapped_count", xfer_count, m_count - 256);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
